// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: Gray conversion helper and default sizing
// used by both the read-side and write-side pointer controllers.
package fifo_pkg;

  localparam int FIFO_ASIZE_DEFAULT = 4;
  localparam int SYNC_STAGES        = 2;

  // Width-generic: callers cast the argument up and the result back down.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/fifo_flag_sync.sv
// Flag synchronizer: asserts asynchronously whenever rst or the active-low
// async input is asserted, and releases only after STAGES clean clock edges.
module fifo_flag_sync
  import fifo_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic async_n,
  output logic flag
);

  logic              set;
  logic [STAGES-1:0] sync;

  assign set = rst | ~async_n;

  // Zeros shift in from stage 0; any set event refills the chain with ones,
  // so a glitch on async_n restarts the full release count.
  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      sync <= '1;
    end else begin
      sync <= {sync[STAGES-2:0], 1'b0};
    end
  end

  assign flag = sync[STAGES-1];

endmodule

// File: rtl/fifo_rptr_empty.sv
// Read-side pointer and empty controller for the async FIFO: binary RAM
// address, Gray pointer to the comparator, clean rempty, rvalid, underflow.
module fifo_rptr_empty
  import fifo_pkg::*;
#(
  parameter int ASIZE = FIFO_ASIZE_DEFAULT
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rinc,
  input  logic             aempty_n,
  input  logic             rerr_clr,
  output logic [ASIZE-1:0] rptr,
  output logic [ASIZE-1:0] raddr,
  output logic             rempty,
  output logic             rvalid,
  output logic             rerr_underflow
);

  // Handshake: a read is accepted on an rclk edge when rinc=1 and the
  // pre-edge rempty=0; rvalid is high for exactly the following cycle,
  // when the RAM output holds the word at the accepted raddr. rinc while
  // empty is dropped and flagged as underflow.
  logic             rd_acc;
  logic [ASIZE-1:0] rbin;
  logic [ASIZE-1:0] rbnext;
  logic [ASIZE-1:0] rgnext;

  assign rd_acc = rinc & ~rempty;
  assign rbnext = rbin + ASIZE'(rd_acc);
  assign rgnext = ASIZE'(bin2gray(32'(rbnext)));

  // rptr is a bare flop so the comparator never sees decode glitches.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin           <= '0;
      rptr           <= '0;
      rvalid         <= 1'b0;
      rerr_underflow <= 1'b0;
    end else begin
      rbin   <= rbnext;
      rptr   <= rgnext;
      rvalid <= rd_acc;
      if (rinc & rempty) begin
        rerr_underflow <= 1'b1;
      end else if (rerr_clr) begin
        rerr_underflow <= 1'b0;
      end
    end
  end

  assign raddr = rbin;

  fifo_flag_sync #(
    .STAGES (SYNC_STAGES)
  ) u_empty_sync (
    .clk     (rclk),
    .rst     (rrst),
    .async_n (aempty_n),
    .flag    (rempty)
  );

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Bench for fifo_rptr_empty: a model write side and comparator feed it, a
// RAM model supplies data, and a scoreboard checks every rvalid word.
module tb_fifo_rptr_empty;

  localparam int ASIZE = 4;
  localparam int DEPTH = 1 << ASIZE;

  // clock / reset
  logic rclk = 1'b0;
  logic rrst = 1'b1;
  always #5 rclk = ~rclk;

  logic             rinc = 1'b0;
  logic             rerr_clr = 1'b0;
  logic             glitch = 1'b0;
  logic             aempty_n;
  logic [ASIZE-1:0] rptr;
  logic [ASIZE-1:0] raddr;
  logic             rempty;
  logic             rvalid;
  logic             rerr_underflow;

  fifo_rptr_empty #(.ASIZE(ASIZE)) dut (
    .rclk           (rclk),
    .rrst           (rrst),
    .rinc           (rinc),
    .aempty_n       (aempty_n),
    .rerr_clr       (rerr_clr),
    .rptr           (rptr),
    .raddr          (raddr),
    .rempty         (rempty),
    .rvalid         (rvalid),
    .rerr_underflow (rerr_underflow)
  );

  // environment: write side, comparator and synchronous RAM
  int               wcount;
  int               rcount;
  logic [ASIZE-1:0] wbin;
  logic [ASIZE-1:0] wgray;
  logic [7:0]       mem [DEPTH];
  logic [7:0]       rdata;

  assign wbin     = ASIZE'(wcount);
  assign wgray    = wbin ^ (wbin >> 1);
  assign aempty_n = ~glitch & (rptr != wgray);

  always @(posedge rclk) rdata <= mem[raddr];

  // reference model state
  logic [7:0] data_q[$];
  logic [7:0] exp_q[$];
  int         clean_edges;
  bit         m_empty;
  bit         m_rvalid;
  bit         m_err;
  int         n_cmp;
  int         n_err;

  task automatic cmp(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int gray_of(input int count);
    int b;
    b = count % DEPTH;
    return b ^ (b / 2);
  endfunction

  task automatic model_reset();
    wcount      = 0;
    rcount      = 0;
    clean_edges = 0;
    m_empty     = 1'b1;
    m_rvalid    = 1'b0;
    m_err       = 1'b0;
    data_q.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs();
    cmp("raddr", int'(raddr), rcount % DEPTH);
    cmp("rptr", int'(rptr), gray_of(rcount));
    cmp("rempty", int'(rempty), int'(m_empty));
    cmp("rvalid", int'(rvalid), int'(m_rvalid));
    cmp("rerr_underflow", int'(rerr_underflow), int'(m_err));
  endtask

  // one rclk cycle: check, drive at negedge, update model at posedge
  task automatic cycle(input bit ri, input bit wr, input bit clr, input bit gl);
    bit acc;
    @(negedge rclk);
    check_outputs();
    rinc     = ri;
    rerr_clr = clr;
    if (wr && (wcount - rcount) < DEPTH - 1) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      mem[ASIZE'(wcount)] = d;
      data_q.push_back(d);
      wcount++;
    end
    if (gl) begin
      glitch = 1'b1;
      #1;
      glitch = 1'b0;
      clean_edges = 0;
      m_empty = 1'b1;
    end
    @(posedge rclk);
    acc      = ri && !m_empty;
    m_rvalid = acc;
    if (acc) begin
      rcount++;
      exp_q.push_back(data_q.pop_front());
    end
    if (ri && m_empty) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    // empty releases after two clock edges with the FIFO non-empty
    if (wcount == rcount) clean_edges = 0;
    else if (clean_edges < 2) clean_edges++;
    m_empty = (clean_edges < 2);
  endtask

  task automatic do_reset();
    @(negedge rclk);
    check_outputs();
    rrst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge rclk);
    #1;
    check_outputs();
    @(negedge rclk);
    rinc     = 1'b0;
    rerr_clr = 1'b0;
    rrst     = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge rclk) begin
    if (!rrst && rvalid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rdata: rvalid with no read expected at %0t", $time);
      end else begin
        cmp("rdata", int'(rdata), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    bit reached;
    n_cmp = 0;
    n_err = 0;
    model_reset();
    repeat (2) @(negedge rclk);
    check_outputs();
    rrst = 1'b0;

    // underflow set, clear, and set winning over clear
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 0);
    // empty release, then a glitch before the second edge
    cycle(0, 1, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 0);
    // burst of three reads, then drain into self-empty with rinc held
    repeat (2) cycle(0, 1, 0, 0);
    repeat (5) cycle(1, 0, 0, 0);

    repeat (800) begin
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
            $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
    end

    // reset in the middle of traffic at raddr=5
    reached = 1'b0;
    for (int i = 0; i < 400 && !reached; i++) begin
      cycle($urandom_range(0, 9) < 5, $urandom_range(0, 9) < 7, 1'b0, 1'b0);
      if (rcount % DEPTH == 5 && wcount != rcount) reached = 1'b1;
    end
    cmp("reach_raddr5", int'(reached), 1);
    do_reset();

    repeat (200) begin
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
            $urandom_range(0, 9) == 0, 1'b0);
    end
    repeat (40) cycle(1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    cmp("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rptr_empty.md
Name: fifo_rptr_empty

Overview:
Read-side pointer and empty-flag controller for the async FIFO, style 2 (quadrant-direction compare).
- Generates the Gray-coded read pointer consumed by the async pointer comparator and the binary RAM read address.
- Consumes the comparator's asynchronous aempty_n and turns it into a read-clock-clean rempty: asynchronous assert, two-flop synchronized deassert.
- Adds a one-cycle read-data-valid strobe for the synchronous RAM and a sticky underflow error.

Parameters:
- ASIZE, 4, address/pointer width in bits; FIFO depth is 2^ASIZE; legal range is ASIZE >= 2 (the comparator uses bits ASIZE-1 and ASIZE-2).

Ports:
- rclk  input  1  read-domain clock, rising edge
- rrst  input  1  asynchronous, active-high reset
- rinc  input  1  read request
- aempty_n  input  1  asynchronous empty from comparator, active low, may change at any time
- rerr_clr  input  1  synchronous clear of rerr_underflow
- rptr  output  ASIZE  Gray-coded read pointer, registered, to comparator
- raddr  output  ASIZE  binary read address to RAM, registered
- rempty  output  1  synchronized empty flag
- rvalid  output  1  RAM read data valid
- rerr_underflow  output  1  sticky underflow error

Behaviour:
- Interface: one clock, rclk. Reset rrst is asynchronous and active-high.
- Reset values:
  - rptr = 0, raddr = 0.
  - rempty = 1; both synchronizer stages = 1.
  - rvalid = 0, rerr_underflow = 0.
- Accept rule: rd_acc = rinc & ~rempty, using rempty as sampled before the edge.
- Binary counter:
  - rbnext = rbin + rd_acc, modulo 2^ASIZE; raddr = rbin.
- Gray pointer:
  - rgnext = (rbnext >> 1) ^ rbnext; rptr <= rgnext on rclk.
  - rptr and raddr change on the same edge; 0 cycles latency from accept to pointer update.
  - rptr changes at most one bit per edge; it is driven directly by a flop, with no combinational logic after the register.
- Wrap-around: raddr 2^ASIZE-1 -> 0; rptr 100..0 -> 000..0 (single-bit change). No special handling.
- Empty synchronizer: two flops, e2 then rempty, both asynchronously set to 1 when (rrst | ~aempty_n).
  - Otherwise each edge: e2 <= 0, rempty <= e2.
- Empty assert is asynchronous, with no clock needed. When a read makes rptr == wptr with direction=0, the comparator drops aempty_n after rptr's clock-to-q, and rempty rises within the same cycle. An over-read on the next edge is therefore impossible.
- Empty deassert: rempty falls on the 2nd rclk rising edge after aempty_n returns high. An aempty_n glitch restarts the 2-edge count.
- rvalid <= rd_acc: high exactly one cycle after each accepted read, aligned with RAM output data.
- Underflow:
  - rinc & rempty at an edge sets rerr_underflow; the pointer does not move and rvalid stays 0.
  - rerr_clr clears it synchronously.
  - Set and clear on the same edge: set wins.
- Simultaneous events: rinc on the edge where rempty falls is not accepted, since the pre-edge rempty = 1; this also counts as underflow.
- Reset mid-operation: all state returns to reset values immediately. The write side and comparator direction must be reset in the same window; the FIFO top level guarantees this.
- No X propagation from rinc/rerr_clr into state while in reset.

Decomposition:
- Shared package fifo_pkg:
  - bin2gray function (generic width).
  - FIFO_ASIZE_DEFAULT = 4.
  - SYNC_STAGES = 2.
- Sub-module fifo_flag_sync: a 2-stage synchronizer with asynchronous set on (rst | ~async_n) and synchronous deassert.
  - Instantiated here for rempty.
  - Reused unchanged by the write-side full controller for afull_n.
- Counter, underflow and rvalid logic stay inline.

Test Plan (ASIZE=4):
- Reset: assert rrst mid-traffic at raddr=5 -> outputs immediately rptr=0000, raddr=0, rempty=1, rvalid=0, rerr_underflow=0.
- Empty release: aempty_n 0 -> 1 between edges -> rempty still 1 after edge 1, 0 after edge 2; aempty_n glitch low for 1 ns before edge 2 -> rempty back to 1 at once, then needs 2 full edges.
- Reads: rempty=0, aempty_n=1, rinc high 3 cycles -> raddr 0,1,2,3; rptr 0000,0001,0011,0010; rvalid high the cycle after each accepted read (3 consecutive cycles).
- Wrap: from raddr=15 (rptr=1000), one read -> raddr=0, rptr=0000; exactly one rptr bit toggles.
- Self-empty: model comparator returning aempty_n = ~(rptr==wptr) with wptr=0011 and reads from raddr=0 -> after rptr becomes 0011, rempty rises before the next edge; rinc held high -> raddr stays 2 (binary 0010), rerr_underflow=1 next edge.
- Underflow sticky: rerr_underflow=1, then rerr_clr=1 with rinc=0 -> clears next edge; rerr_clr=1 with rinc=1 and rempty=1 on the same edge -> stays 1.
